otter_cu_fsm: RTL and testbench
===============================

// Module: otter_cu_fsm
// PURPOSE
//  Multi-cycle sequencer for the OTTER core: steps each instruction through FETCH/EXEC/WB, drives PC, register-file,
//  memory and CSR enables, and takes interrupts between instructions. It sits beside the combinational decoder;
//  the decoder selects datapath muxes, this block decides when state is written. It also counts retired instructions.
// PARAMETERS
//  CNT_W     32  width of retired-instruction counter
// PORTS
//  CLK        in   1      core clock; all state updates on rising edge
//  RST        in   1      synchronous, active-high reset
//  opcode     in   7      ir[6:0]
//  func3      in   3      ir[14:12]
//  intr       in   1      external interrupt request (level)
//  mie        in   1      CSR mstatus.MIE; interrupts taken only when 1
//  imem_rdy   in   1      instruction memory data valid this cycle
//  dmem_rdy   in   1      data memory access complete this cycle
//  PCWrite    out  1      PC register load enable
//  regWrite   out  1      register-file write enable
//  memWE2     out  1      data memory write enable
//  memRDEN1   out  1      instruction memory read enable
//  memRDEN2   out  1      data memory read enable
//  rst_o      out  1      datapath reset (PC <- 0)
//  csr_WE     out  1      CSR write enable (CSRRW)
//  int_taken  out  1      interrupt entry this cycle (decoder then selects mtvec)
//  mret_exec  out  1      MRET executing this cycle
//  instret    out  CNT_W  retired-instruction count
// BEHAVIOUR
//  States: ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR. Outputs are a combinational function of state, opcode, func3 and rdy.
//  Reset: while RST=1 every enable output is forced 0 and rst_o=1. On the next edge state<=ST_INIT and instret<=0.
//   RST mid-instruction abandons it; nothing retires.
//  ST_INIT: rst_o=1 -> ST_FETCH.
//  ST_FETCH: memRDEN1=1. imem_rdy=1 -> ST_EXEC; otherwise hold with memRDEN1 kept high.
//  ST_EXEC, by opcode:
//   LOAD   0000011: memRDEN2=1, PCWrite=0 -> ST_WB.
//   STORE  0100011: memWE2=1. dmem_rdy=1 -> PCWrite=1, commit. Otherwise hold in ST_EXEC, memWE2 stays high, no PCWrite.
//   BRANCH 1100011: PCWrite=1, regWrite=0, commit.
//   SYS    1110011: func3=000 -> mret_exec=1, PCWrite=1. func3=001 -> csr_WE=1, regWrite=1, PCWrite=1.
//     Other func3 -> PCWrite=1 only. All commit.
//   LUI/AUIPC/JAL/JALR/OP_IMM/RTYPE: PCWrite=1, regWrite=1, commit.
//   Unrecognised opcode: PCWrite=1 only (treated as NOP), commit.
//  ST_WB: memRDEN2=1. dmem_rdy=1 -> regWrite=1, PCWrite=1, commit. Otherwise hold with no writes.
//  Commit: instret += 1 (wraps modulo 2^CNT_W). Next state is ST_INTR if (intr & mie), else ST_FETCH.
//   intr is sampled only in the commit cycle; an intr pulse outside commit is ignored.
//  ST_INTR: int_taken=1, PCWrite=1; no regWrite, no instret increment -> ST_FETCH.
//   Interrupts cannot nest: ST_INTR never goes back to ST_INTR.
//  MRET committing with intr&mie=1 goes to ST_INTR (the new mie value is sampled from the CSR input).
//  Exactly one of PCWrite/stall per cycle. memWE2 and regWrite are never both 1.
// STRUCTURE
//  otter_pkg: opcode_t (shared with the decoder), cu_state_t, SYS func3 constants (F3_MRET=000, F3_CSRRW=001).
//  Sub-module otter_instret_ctr: CNT_W counter with sync clear and increment enable.
//  Everything else in one state register and one always_comb output/next-state block.
// TESTING
//  1 RST=1 for 2 cycles, release, imem_rdy=1 -> rst_o=1 in ST_INIT, memRDEN1=1 next cycle, instret=0.
//  2 ADDI (0010011), rdy=1 -> 2 cycles FETCH,EXEC. In EXEC PCWrite=regWrite=1. instret 0->1.
//  3 LW with dmem_rdy low 3 cycles in ST_WB -> regWrite only on the rdy cycle. 3 WB stall cycles have all writes 0.
//    Load total 6 cycles. SW with dmem_rdy low 2 cycles -> memWE2 held 3 cycles, PCWrite on the last one.
//  4 intr=1, mie=1 during ADD commit -> next cycle int_taken=PCWrite=1, then FETCH. With mie=0 no ST_INTR.
//    intr pulsed only in FETCH -> ignored.
//  5 CSRRW (1110011, f3=001) -> csr_WE=regWrite=PCWrite=1. MRET (f3=000) -> mret_exec=1, csr_WE=0.
//  6 RST asserted in ST_WB of a load -> no regWrite, instret unchanged, ST_INIT next. instret preset to 2^CNT_W-1 -> wraps to 0.

Source files
------------

// File: rtl/otter_cu_fsm_pkg.sv
// Shared types for the OTTER control unit: opcode encodings, sequencer states
// and the SYSTEM-instruction func3 values the sequencer distinguishes.
package otter_cu_fsm_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_SYS    = 7'b1110011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_IMM    = 7'b0010011,
    OP_RTYPE  = 7'b0110011
  } opcode_t;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } cu_state_t;

  localparam logic [2:0] F3_MRET  = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;

endpackage

// File: rtl/otter_cu_fsm_instret_ctr.sv
// Retired-instruction counter: synchronous clear wins over increment,
// and the count wraps naturally at 2^CNT_W.
module otter_instret_ctr #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count register update.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (inc_i) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/otter_cu_fsm.sv
// OTTER multi-cycle sequencer: walks each instruction through FETCH/EXEC/WB,
// raises the write enables, and enters the trap vector between instructions.
module otter_cu_fsm
  import otter_cu_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             intr,
  input  logic             mie,
  input  logic             imem_rdy,
  input  logic             dmem_rdy,
  output logic             PCWrite,
  output logic             regWrite,
  output logic             memWE2,
  output logic             memRDEN1,
  output logic             memRDEN2,
  output logic             rst_o,
  output logic             csr_WE,
  output logic             int_taken,
  output logic             mret_exec,
  output logic [CNT_W-1:0] instret
);

  cu_state_t state_q, state_d;
  cu_state_t after_commit_s;
  logic      commit_s;

  // intr is only looked at when an instruction retires.
  assign after_commit_s = (intr && mie) ? ST_INTR : ST_FETCH;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Output enables and next state.
  always_comb begin
    state_d   = state_q;
    commit_s  = 1'b0;
    PCWrite   = 1'b0;
    regWrite  = 1'b0;
    memWE2    = 1'b0;
    memRDEN1  = 1'b0;
    memRDEN2  = 1'b0;
    rst_o     = 1'b0;
    csr_WE    = 1'b0;
    int_taken = 1'b0;
    mret_exec = 1'b0;
    if (RST) begin
      rst_o   = 1'b1;
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: begin
          rst_o   = 1'b1;
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          memRDEN1 = 1'b1;
          if (imem_rdy) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_EXEC: begin
          case (opcode)
            OP_LOAD: begin
              memRDEN2 = 1'b1;
              state_d  = ST_WB;
            end
            OP_STORE: begin
              memWE2 = 1'b1;
              if (dmem_rdy) begin
                PCWrite  = 1'b1;
                commit_s = 1'b1;
                state_d  = after_commit_s;
              end else begin
                state_d = ST_EXEC;
              end
            end
            OP_SYS: begin
              PCWrite  = 1'b1;
              commit_s = 1'b1;
              state_d  = after_commit_s;
              if (func3 == F3_MRET) begin
                mret_exec = 1'b1;
              end else if (func3 == F3_CSRRW) begin
                csr_WE   = 1'b1;
                regWrite = 1'b1;
              end else begin
                mret_exec = 1'b0;
              end
            end
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RTYPE: begin
              PCWrite  = 1'b1;
              regWrite = 1'b1;
              commit_s = 1'b1;
              state_d  = after_commit_s;
            end
            // BRANCH and unknown opcodes only advance the PC.
            default: begin
              PCWrite  = 1'b1;
              commit_s = 1'b1;
              state_d  = after_commit_s;
            end
          endcase
        end
        ST_WB: begin
          memRDEN2 = 1'b1;
          if (dmem_rdy) begin
            regWrite = 1'b1;
            PCWrite  = 1'b1;
            commit_s = 1'b1;
            state_d  = after_commit_s;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_INTR: begin
          int_taken = 1'b1;
          PCWrite   = 1'b1;
          state_d   = ST_FETCH;
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end
  end

  otter_instret_ctr #(
    .CNT_W(CNT_W)
  ) u_instret (
    .clk_i(CLK),
    .clr_i(RST),
    .inc_i(commit_s),
    .cnt_o(instret)
  );

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed-vector bench for otter_cu_fsm with a queue scoreboard; a second
// instance with a 3-bit counter shares the stimulus to exercise wraparound.
module tb_otter_cu_fsm;

  logic        CLK, RST, intr, mie, imem_rdy, dmem_rdy;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, rst_o, csr_WE, int_taken, mret_exec;
  logic [31:0] instret;
  logic        s_pcw, s_rw, s_we2, s_rd1, s_rd2, s_rst, s_csr, s_int, s_mret;
  logic [2:0]  s_instret;

  otter_cu_fsm dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .func3(func3), .intr(intr), .mie(mie),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .PCWrite(PCWrite), .regWrite(regWrite),
    .memWE2(memWE2), .memRDEN1(memRDEN1), .memRDEN2(memRDEN2), .rst_o(rst_o),
    .csr_WE(csr_WE), .int_taken(int_taken), .mret_exec(mret_exec), .instret(instret)
  );

  otter_cu_fsm #(.CNT_W(3)) dut_small (
    .CLK(CLK), .RST(RST), .opcode(opcode), .func3(func3), .intr(intr), .mie(mie),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .PCWrite(s_pcw), .regWrite(s_rw),
    .memWE2(s_we2), .memRDEN1(s_rd1), .memRDEN2(s_rd2), .rst_o(s_rst),
    .csr_WE(s_csr), .int_taken(s_int), .mret_exec(s_mret), .instret(s_instret)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output bits: {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, rst_o, csr_WE, int_taken, mret_exec}
  localparam logic [8:0] E_RST   = 9'b000_001_000;
  localparam logic [8:0] E_FETCH = 9'b000_100_000;
  localparam logic [8:0] E_ALU   = 9'b110_000_000;
  localparam logic [8:0] E_PC    = 9'b100_000_000;
  localparam logic [8:0] E_RD2   = 9'b000_010_000;
  localparam logic [8:0] E_WBW   = 9'b110_010_000;
  localparam logic [8:0] E_ST    = 9'b001_000_000;
  localparam logic [8:0] E_STC   = 9'b101_000_000;
  localparam logic [8:0] E_INT   = 9'b100_000_010;
  localparam logic [8:0] E_CSR   = 9'b110_000_100;
  localparam logic [8:0] E_MRET  = 9'b100_000_001;

  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] SYS  = 7'b1110011;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef struct {
    int          id;
    logic [8:0]  outs;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          n_vec = 0;
  int          n_err = 0;
  int          vid = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [8:0]  act, act_s;

  // Scoreboard monitor: outputs are settled mid-cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      cur   = exp_q.pop_front();
      act   = {PCWrite, regWrite, memWE2, memRDEN1, memRDEN2, rst_o, csr_WE, int_taken, mret_exec};
      act_s = {s_pcw, s_rw, s_we2, s_rd1, s_rd2, s_rst, s_csr, s_int, s_mret};
      n_vec++;
      if (act !== cur.outs || instret !== cur.cnt || act_s !== cur.outs || s_instret !== cur.cnt[2:0]) begin
        n_err++;
        $display("FAIL vec%0d: got outs=%b instret=%0d small_outs=%b small_instret=%0d, expected outs=%b instret=%0d small_instret=%0d",
                 cur.id, act, instret, act_s, s_instret, cur.outs, cur.cnt, cur.cnt[2:0]);
      end
    end
  end

  task automatic step(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                      input logic it, input logic mi, input logic ir, input logic dr,
                      input logic [8:0] ex, input logic cm);
    @(posedge CLK);
    #1;
    RST = rst; opcode = op; func3 = f3; intr = it; mie = mi; imem_rdy = ir; dmem_rdy = dr;
    exp_q.push_back('{id: vid, outs: ex, cnt: exp_cnt});
    vid++;
    if (rst) exp_cnt = 32'd0;
    else if (cm) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    RST = 1'b1; opcode = ADDI; func3 = 3'd0; intr = 1'b0; mie = 1'b0; imem_rdy = 1'b1; dmem_rdy = 1'b0;
    repeat (2) @(posedge CLK);
    // reset held, then release into INIT and FETCH
    step(1'b1, ADDI, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_RST,   1'b0);
    step(1'b0, ADDI, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_RST,   1'b0);
    // ADDI
    step(1'b0, ADDI, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, ADDI, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_ALU,   1'b1);
    // fetch stall then LW with 3 WB stall cycles
    step(1'b0, LW,   3'd2, 1'b0, 1'b0, 1'b0, 1'b0, E_FETCH, 1'b0);
    step(1'b0, LW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, LW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_RD2,   1'b0);
    step(1'b0, LW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_RD2,   1'b0);
    step(1'b0, LW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_RD2,   1'b0);
    step(1'b0, LW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_RD2,   1'b0);
    step(1'b0, LW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b1, E_WBW,   1'b1);
    // SW with 2 stall cycles
    step(1'b0, SW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, SW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_ST,    1'b0);
    step(1'b0, SW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_ST,    1'b0);
    step(1'b0, SW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b1, E_STC,   1'b1);
    // ADD commit with intr & mie: trap entry, intr still high in INTR
    step(1'b0, ADD,  3'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, ADD,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, E_ALU,   1'b1);
    step(1'b0, ADD,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, E_INT,   1'b0);
    // intr with mie=0 at commit: no trap
    step(1'b0, ADD,  3'd0, 1'b1, 1'b0, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, ADD,  3'd0, 1'b1, 1'b0, 1'b1, 1'b0, E_ALU,   1'b1);
    // intr pulse only in FETCH: ignored
    step(1'b0, ADD,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, ADD,  3'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_ALU,   1'b1);
    // CSRRW, then MRET committing with intr & mie
    step(1'b0, SYS,  3'd1, 1'b0, 1'b0, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, SYS,  3'd1, 1'b0, 1'b0, 1'b1, 1'b0, E_CSR,   1'b1);
    step(1'b0, SYS,  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, SYS,  3'd0, 1'b1, 1'b1, 1'b1, 1'b0, E_MRET,  1'b1);
    step(1'b0, SYS,  3'd0, 1'b0, 1'b1, 1'b1, 1'b0, E_INT,   1'b0);
    // BRANCH, unknown opcode, SYS with other func3
    step(1'b0, BR,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, BR,   3'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_PC,    1'b1);
    step(1'b0, BAD,  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, BAD,  3'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_PC,    1'b1);
    step(1'b0, SYS,  3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, SYS,  3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_PC,    1'b1);
    // RST in WB of a load: no writes, nothing retires, back to INIT
    step(1'b0, LW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, LW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b0, E_RD2,   1'b0);
    step(1'b1, LW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b1, E_RST,   1'b0);
    step(1'b0, LW,   3'd2, 1'b0, 1'b0, 1'b1, 1'b1, E_RST,   1'b0);
    step(1'b0, ADDI, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FETCH, 1'b0);
    step(1'b0, ADDI, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_ALU,   1'b1);
    step(1'b0, ADDI, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_FETCH, 1'b0);
    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
